uart_rx: RTL and testbench

UART receiver that deserialises the asynchronous `rx` line into parallel bytes using 16x oversampling. It sits directly downstream of the baud rate generator and consumes its `sample_tick` pulse, one tick per 1/16 bit period. It presents each received word with a one-cycle valid strobe and per-frame error flags to the host-side logic. Frame format is 1 start bit, `DATA_BITS` data bits LSB first, optional parity, and 1 stop bit.

---
 rtl/uart_rx.sv | 134 +++++++++++++
 tb/tb_uart_rx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 1 start bit, DATA_BITS data bits LSB first,
// optional parity, 1 stop bit. Outputs are registered one-cycle strobes.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 framing_err,
    output logic                 busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic       PAR_EN   = (PARITY_EN != 0);
    localparam logic       PAR_ODD  = (PARITY_ODD != 0);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_t                 state_q;
    logic                   rx_meta_q;
    logic                   rx_s_q;
    logic [3:0]             tick_cnt_q;
    logic [2:0]             bit_cnt_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_bit_q;
    logic                   armed_q;
    logic [DATA_BITS-1:0]   rx_data_q;
    logic                   rx_valid_q;
    logic                   parity_err_q;
    logic                   framing_err_q;
    logic                   busy_q;
    logic                   par_mismatch;

    assign par_mismatch = PAR_EN && (par_bit_q != ((^shift_q) ^ PAR_ODD));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            par_bit_q     <= 1'b0;
            armed_q       <= 1'b1;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            rx_meta_q     <= rx;
            rx_s_q        <= rx_meta_q;
            rx_valid_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            if (sample_tick) begin
                tick_cnt_q <= tick_cnt_q + 4'd1;
                case (state_q)
                    IDLE: begin
                        // After a break the line must be seen high before a new start is accepted.
                        if (rx_s_q) begin
                            armed_q <= 1'b1;
                        end else if (armed_q) begin
                            state_q    <= START;
                            tick_cnt_q <= '0;
                            busy_q     <= 1'b1;
                        end
                    end
                    START: begin
                        if (tick_cnt_q == 4'd7) begin
                            tick_cnt_q <= '0;
                            if (!rx_s_q) begin
                                state_q   <= DATA;
                                bit_cnt_q <= '0;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    DATA: begin
                        if (tick_cnt_q == 4'd15) begin
                            shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                            if (bit_cnt_q == LAST_BIT) begin
                                tick_cnt_q <= '0;
                                state_q    <= PAR_EN ? PARITY : STOP;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                    end
                    PARITY: begin
                        if (tick_cnt_q == 4'd15) begin
                            par_bit_q  <= rx_s_q;
                            tick_cnt_q <= '0;
                            state_q    <= STOP;
                        end
                    end
                    STOP: begin
                        if (tick_cnt_q == 4'd15) begin
                            rx_data_q     <= shift_q;
                            rx_valid_q    <= rx_s_q && !par_mismatch;
                            framing_err_q <= !rx_s_q;
                            parity_err_q  <= par_mismatch;
                            armed_q       <= rx_s_q;
                            tick_cnt_q    <= '0;
                            state_q       <= IDLE;
                            busy_q        <= 1'b0;
                        end
                    end
                    default: begin
                        state_q    <= IDLE;
                        tick_cnt_q <= '0;
                        busy_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign parity_err  = parity_err_q;
    assign framing_err = framing_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three instances (8N1, 8E1, 8O1) share one serial line;
// each test checks only the instance whose frame format it drives.
module tb_uart_rx;

    logic clk;
    logic reset;
    logic sample_tick;
    logic rx;
    logic fast;

    logic [2:0][7:0] dat_w;
    logic [2:0]      val_w;
    logic [2:0]      perr_w;
    logic [2:0]      ferr_w;
    logic [2:0]      busy_w;

    int vcnt [3];
    int pcnt [3];
    int fcnt [3];

    int errors;
    int checks;

    uart_rx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_n (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .rx(rx),
        .rx_data(dat_w[0]), .rx_valid(val_w[0]), .parity_err(perr_w[0]),
        .framing_err(ferr_w[0]), .busy(busy_w[0]));

    uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_e (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .rx(rx),
        .rx_data(dat_w[1]), .rx_valid(val_w[1]), .parity_err(perr_w[1]),
        .framing_err(ferr_w[1]), .busy(busy_w[1]));

    uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) u_o (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .rx(rx),
        .rx_data(dat_w[2]), .rx_valid(val_w[2]), .parity_err(perr_w[2]),
        .framing_err(ferr_w[2]), .busy(busy_w[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick generator: one tick per 16 clk, or stuck high in fast mode.
    initial begin
        int tdiv;
        tdiv = 0;
        sample_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (fast) begin
                sample_tick = 1'b1;
            end else begin
                tdiv = (tdiv + 1) % 16;
                sample_tick = (tdiv == 0);
            end
        end
    end

    // Pulse counters sampled on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (val_w[i])  vcnt[i] = vcnt[i] + 1;
            if (perr_w[i]) pcnt[i] = pcnt[i] + 1;
            if (ferr_w[i]) fcnt[i] = fcnt[i] + 1;
        end
    end

    typedef struct {
        int         dut;
        logic       fast;
        logic [7:0] d;
        logic       par_v;
        logic       stop_v;
        logic [7:0] exp_d;
        int         exp_v;
        int         exp_p;
        int         exp_f;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold_rx(input logic v, input int clks);
        rx = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic use_par,
                              input logic par_v, input logic stop_v);
        int bc;
        bc = fast ? 16 : 256;
        hold_rx(1'b0, bc);
        for (int i = 0; i < 8; i++) hold_rx(d[i], bc);
        if (use_par) hold_rx(par_v, bc);
        hold_rx(stop_v, bc);
        rx = 1'b1;
    endtask

    initial begin
        int sv, sp, sf, k;
        errors = 0;
        checks = 0;
        for (int i = 0; i < 3; i++) begin
            vcnt[i] = 0; pcnt[i] = 0; fcnt[i] = 0;
        end
        fast  = 1'b0;
        rx    = 1'b1;
        reset = 1'b0;

        //           dut fast data   par   stop  exp_d  v  p  f
        vecs[0] = '{0, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1, 0, 0};
        vecs[1] = '{0, 1'b0, 8'h55, 1'b0, 1'b0, 8'h55, 0, 0, 1};
        vecs[2] = '{2, 1'b0, 8'h03, 1'b0, 1'b1, 8'h03, 0, 1, 0};
        vecs[3] = '{2, 1'b0, 8'h03, 1'b1, 1'b1, 8'h03, 1, 0, 0};
        vecs[4] = '{1, 1'b0, 8'h07, 1'b1, 1'b1, 8'h07, 1, 0, 0};
        vecs[5] = '{1, 1'b0, 8'h07, 1'b0, 1'b0, 8'h07, 0, 1, 1};
        vecs[6] = '{0, 1'b1, 8'hC3, 1'b0, 1'b1, 8'hC3, 1, 0, 0};
        vecs[7] = '{1, 1'b1, 8'h80, 1'b1, 1'b1, 8'h80, 1, 0, 0};

        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_data",  int'(dat_w[i]),  0);
            chk("reset_valid", int'(val_w[i]),  0);
            chk("reset_perr",  int'(perr_w[i]), 0);
            chk("reset_ferr",  int'(ferr_w[i]), 0);
            chk("reset_busy",  int'(busy_w[i]), 0);
        end
        reset = 1'b1;
        hold_rx(1'b1, 600);

        for (int i = 0; i < 8; i++) begin
            k = vecs[i].dut;
            fast = vecs[i].fast;
            hold_rx(1'b1, 600);
            sv = vcnt[k]; sp = pcnt[k]; sf = fcnt[k];
            send_frame(vecs[i].d, k != 0, vecs[i].par_v, vecs[i].stop_v);
            repeat (4) @(negedge clk);
            $display("vec %0d dut=%0d fast=%0b d=%02h: rx_data=%02h v=%0d p=%0d f=%0d",
                     i, k, vecs[i].fast, vecs[i].d, dat_w[k],
                     vcnt[k] - sv, pcnt[k] - sp, fcnt[k] - sf);
            chk("vec_data",  int'(dat_w[k]),  int'(vecs[i].exp_d));
            chk("vec_valid", vcnt[k] - sv,    vecs[i].exp_v);
            chk("vec_perr",  pcnt[k] - sp,    vecs[i].exp_p);
            chk("vec_ferr",  fcnt[k] - sf,    vecs[i].exp_f);
            chk("vec_busy",  int'(busy_w[k]), 0);
            hold_rx(1'b1, 600);
        end
        fast = 1'b0;
        hold_rx(1'b1, 600);

        // Back-to-back 8E1 frames with no idle gap.
        sv = vcnt[1]; sp = pcnt[1]; sf = fcnt[1];
        send_frame(8'h00, 1'b1, 1'b0, 1'b1);
        chk("b2b_first_data", int'(dat_w[1]), 8'h00);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        $display("b2b 8E1 00,FF: rx_data=%02h v=%0d p=%0d", dat_w[1], vcnt[1] - sv, pcnt[1] - sp);
        chk("b2b_second_data", int'(dat_w[1]), 8'hFF);
        chk("b2b_valid", vcnt[1] - sv, 2);
        chk("b2b_perr",  pcnt[1] - sp, 0);
        chk("b2b_ferr",  fcnt[1] - sf, 0);
        hold_rx(1'b1, 600);

        // Glitch: low for 4 ticks, then high.
        sv = vcnt[0]; sp = pcnt[0]; sf = fcnt[0];
        hold_rx(1'b0, 40);
        chk("glitch_busy_rise", int'(busy_w[0]), 1);
        hold_rx(1'b0, 24);
        hold_rx(1'b1, 300);
        $display("glitch: busy=%0b pulses=%0d", busy_w[0],
                 (vcnt[0] - sv) + (pcnt[0] - sp) + (fcnt[0] - sf));
        chk("glitch_busy", int'(busy_w[0]), 0);
        chk("glitch_pulses", (vcnt[0] - sv) + (pcnt[0] - sp) + (fcnt[0] - sf), 0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        $display("after glitch 3C: rx_data=%02h v=%0d", dat_w[0], vcnt[0] - sv);
        chk("glitch_next_data",  int'(dat_w[0]), 8'h3C);
        chk("glitch_next_valid", vcnt[0] - sv, 1);
        hold_rx(1'b1, 600);

        // Break: line held low across more than a frame.
        sv = vcnt[0]; sf = fcnt[0];
        hold_rx(1'b0, 3000);
        $display("break: busy=%0b ferr=%0d v=%0d", busy_w[0], fcnt[0] - sf, vcnt[0] - sv);
        chk("break_ferr",  fcnt[0] - sf, 1);
        chk("break_valid", vcnt[0] - sv, 0);
        chk("break_busy",  int'(busy_w[0]), 0);
        chk("break_data",  int'(dat_w[0]), 8'h00);
        hold_rx(1'b1, 600);
        sv = vcnt[0];
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        $display("after break 5A: rx_data=%02h v=%0d", dat_w[0], vcnt[0] - sv);
        chk("break_next_data",  int'(dat_w[0]), 8'h5A);
        chk("break_next_valid", vcnt[0] - sv, 1);
        hold_rx(1'b1, 600);

        // Reset in the middle of data bit 3 of 0x96.
        sv = vcnt[0]; sp = pcnt[0]; sf = fcnt[0];
        hold_rx(1'b0, 256);
        hold_rx(1'b0, 256);
        hold_rx(1'b1, 256);
        hold_rx(1'b1, 256);
        hold_rx(1'b0, 128);
        chk("midrst_busy_before", int'(busy_w[0]), 1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        $display("reset mid-frame: rx_data=%02h v=%0b p=%0b f=%0b busy=%0b",
                 dat_w[0], val_w[0], perr_w[0], ferr_w[0], busy_w[0]);
        chk("midrst_data",  int'(dat_w[0]),  0);
        chk("midrst_valid", int'(val_w[0]),  0);
        chk("midrst_perr",  int'(perr_w[0]), 0);
        chk("midrst_ferr",  int'(ferr_w[0]), 0);
        chk("midrst_busy",  int'(busy_w[0]), 0);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        hold_rx(1'b1, 600);
        chk("midrst_no_pulse", (vcnt[0] - sv) + (pcnt[0] - sp) + (fcnt[0] - sf), 0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        $display("after reset 81: rx_data=%02h v=%0d", dat_w[0], vcnt[0] - sv);
        chk("midrst_next_data",  int'(dat_w[0]), 8'h81);
        chk("midrst_next_valid", vcnt[0] - sv, 1);
        chk("midrst_next_busy",  int'(busy_w[0]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
